// File: rtl/mc_cpu_controller_v2.sv
// Multi-cycle control FSM for the accumulator CPU.
// Decodes IR/TR instruction words and drives the datapath strobes.
// Memory accesses can stall on mem_ready. A bounded stall aborts to HALT with a sticky error.
module mc_cpu_controller_v2 #(
    parameter int IR_W         = 8,
    parameter int MEM_WAIT_EN  = 1,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mem_ready,
    input  logic [IR_W-1:0] ir,
    input  logic [2:0]      flags,
    output logic            done,
    output logic            err,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            ir_we,
    output logic            tr_we,
    output logic            a_we,
    output logic            b_we,
    output logic            alu_res_we,
    output logic            acc_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            ld_flags,
    output logic            addr_sel,
    output logic            reg_or_mem,
    output logic            reg_sel,
    output logic            a_zero,
    output logic            b_zero,
    output logic [1:0]      alu_op,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ARM    = 4'd1,
        S_FETCH  = 4'd2,
        S_DECODE = 4'd3,
        S_FETCH2 = 4'd4,
        S_RDOPER = 4'd5,
        S_EXEC16 = 4'd6,
        S_WB16   = 4'd7,
        S_LDREG  = 4'd8,
        S_EXEC   = 4'd9,
        S_WBREG  = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [31:0] TIMEOUT_LIM = 32'(WAIT_TIMEOUT);

    state_t      cur;
    logic [31:0] wait_cnt;
    logic [2:0]  op3;
    logic [1:0]  sub;
    logic [1:0]  cond;
    logic        ready;
    logic        mem_state;
    logic        stall;
    logic        timeout;
    logic        unused_ir;

    // sub overlaps the low bit of op3; cond overlaps the low bit of sub
    assign op3  = ir[IR_W-1:IR_W-3];
    assign sub  = ir[IR_W-3:IR_W-4];
    assign cond = ir[IR_W-4:IR_W-5];

    // Operand bits below the opcode fields belong to the datapath, not the controller
    assign unused_ir = ^ir[IR_W-6:0];

    // With wait states disabled, every memory access completes in one cycle
    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // STA reads no operand in RDOPER; only STA touches memory in WB16
    assign mem_state = (cur == S_FETCH) || (cur == S_FETCH2) ||
                       ((cur == S_RDOPER) && (op3 != 3'b001)) ||
                       ((cur == S_WB16) && (op3 == 3'b001));
    assign stall     = mem_state && !ready;
    // Abort on the stalled cycle that makes the stall count reach the limit
    assign timeout   = stall && (WAIT_TIMEOUT != 0) && ((wait_cnt + 32'd1) >= TIMEOUT_LIM);

    assign state = cur;

    // State register, sticky error flag and per-access stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_IDLE;
            err      <= 1'b0;
            wait_cnt <= 32'd0;
        end else begin
            wait_cnt <= (stall && !timeout) ? wait_cnt + 32'd1 : 32'd0;
            if (timeout) begin
                cur <= S_HALT;
                err <= 1'b1;
            end else begin
                case (cur)
                    S_IDLE, S_HALT: begin
                        if (start) begin
                            cur <= S_ARM;
                            err <= 1'b0;
                        end
                    end
                    S_ARM: begin
                        if (!start) cur <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (ready) cur <= S_DECODE;
                    end
                    S_DECODE: begin
                        case (op3)
                            3'b111:         cur <= S_HALT;
                            3'b100, 3'b101: cur <= S_LDREG;
                            default:        cur <= S_FETCH2;
                        endcase
                    end
                    S_FETCH2: begin
                        if (ready) cur <= (op3 == 3'b110) ? S_JUMP : S_RDOPER;
                    end
                    S_RDOPER: begin
                        if ((op3 == 3'b001) || ready) cur <= S_EXEC16;
                    end
                    S_EXEC16: cur <= S_WB16;
                    S_WB16: begin
                        if ((op3 != 3'b001) || ready) cur <= S_FETCH;
                    end
                    S_LDREG: cur <= S_EXEC;
                    S_EXEC:  cur <= S_WBREG;
                    S_WBREG: cur <= S_FETCH;
                    S_JUMP:  cur <= S_FETCH;
                    default: cur <= S_IDLE;
                endcase
            end
        end
    end

    // Datapath strobes decoded from the present state, opcode fields, flags and mem_ready
    always_comb begin
        done       = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        ir_we      = 1'b0;
        tr_we      = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;
        alu_res_we = 1'b0;
        acc_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        ld_flags   = 1'b0;
        addr_sel   = 1'b0;
        reg_or_mem = 1'b0;
        reg_sel    = 1'b0;
        a_zero     = 1'b0;
        b_zero     = 1'b0;
        alu_op     = 2'b00;
        case (cur)
            S_IDLE, S_HALT: done = 1'b1;
            S_FETCH: begin
                mem_re = 1'b1;
                ir_we  = ready;
                pc_inc = ready;
            end
            S_FETCH2: begin
                mem_re = 1'b1;
                tr_we  = ready;
                pc_inc = ready;
            end
            S_RDOPER: begin
                a_we = 1'b1;
                if (op3 != 3'b001) begin
                    addr_sel   = 1'b1;
                    mem_re     = 1'b1;
                    reg_or_mem = 1'b1;
                    b_we       = ready;
                end
            end
            S_EXEC16: begin
                alu_res_we = 1'b1;
                case (op3[1:0])
                    2'b00: begin
                        a_zero   = 1'b1;
                        ld_flags = 1'b1;
                    end
                    2'b01: b_zero = 1'b1;
                    2'b10: ld_flags = 1'b1;
                    default: begin
                        alu_op   = 2'b01;
                        ld_flags = 1'b1;
                    end
                endcase
            end
            S_WB16: begin
                if (op3 == 3'b001) begin
                    addr_sel = 1'b1;
                    mem_we   = 1'b1;
                end else begin
                    acc_we = 1'b1;
                end
            end
            S_LDREG: begin
                a_we    = 1'b1;
                b_we    = 1'b1;
                reg_sel = 1'b1;
            end
            S_EXEC: begin
                alu_res_we = 1'b1;
                case (sub)
                    2'b00: a_zero = 1'b1;
                    2'b01: ld_flags = 1'b1;
                    2'b10: begin
                        alu_op   = 2'b10;
                        ld_flags = 1'b1;
                    end
                    default: begin
                        alu_op   = 2'b11;
                        ld_flags = 1'b1;
                    end
                endcase
            end
            S_WBREG: acc_we = 1'b1;
            S_JUMP: begin
                case (cond)
                    2'b00:   pc_load = 1'b1;
                    2'b01:   pc_load = flags[2];
                    2'b10:   pc_load = flags[1];
                    default: pc_load = flags[0];
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_cpu_controller_v2.sv
// Scoreboard bench for mc_cpu_controller_v2.
// Instance 0 runs with wait states and a 4-cycle timeout; instance 1 ignores mem_ready.
module tb_mc_cpu_controller_v2;

    // Observation word: {state, done, err, pc_inc, pc_load, ir_we, tr_we, a_we, b_we,
    // alu_res_we, acc_we, mem_re, mem_we, ld_flags, addr_sel, reg_or_mem, reg_sel,
    // a_zero, b_zero, alu_op}
    localparam logic [23:0] DONE       = 24'd1 << 19;
    localparam logic [23:0] ERR        = 24'd1 << 18;
    localparam logic [23:0] PC_INC     = 24'd1 << 17;
    localparam logic [23:0] PC_LOAD    = 24'd1 << 16;
    localparam logic [23:0] IR_WE      = 24'd1 << 15;
    localparam logic [23:0] TR_WE      = 24'd1 << 14;
    localparam logic [23:0] A_WE       = 24'd1 << 13;
    localparam logic [23:0] B_WE       = 24'd1 << 12;
    localparam logic [23:0] ALU_RES_WE = 24'd1 << 11;
    localparam logic [23:0] ACC_WE     = 24'd1 << 10;
    localparam logic [23:0] MEM_RE     = 24'd1 << 9;
    localparam logic [23:0] MEM_WE     = 24'd1 << 8;
    localparam logic [23:0] LD_FLAGS   = 24'd1 << 7;
    localparam logic [23:0] ADDR_SEL   = 24'd1 << 6;
    localparam logic [23:0] REG_OR_MEM = 24'd1 << 5;
    localparam logic [23:0] REG_SEL    = 24'd1 << 4;
    localparam logic [23:0] A_ZERO     = 24'd1 << 3;
    localparam logic [23:0] B_ZERO     = 24'd1 << 2;
    localparam logic [23:0] OP_SUB     = 24'd1;
    localparam logic [23:0] OP_AND     = 24'd2;
    localparam logic [23:0] OP_NOT     = 24'd3;

    localparam logic [7:0] IR_ADD  = 8'b010_00000;
    localparam logic [7:0] IR_STA  = 8'b001_00000;
    localparam logic [7:0] IR_NOT  = 8'b10_11_0001;
    localparam logic [7:0] IR_JZ   = 8'b110_10_000;
    localparam logic [7:0] IR_HALT = 8'b111_00000;

    typedef struct {
        int          dut_id;
        logic [23:0] exp;
        string       name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mem_ready;
    logic [7:0]       ir;
    logic [2:0]       flags;
    logic [1:0][23:0] obs;

    exp_t sb[$];
    int   tests;
    int   fails;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [3:0] state;
        logic [1:0] alu_op;
        logic done, err, pc_inc, pc_load, ir_we, tr_we, a_we, b_we, alu_res_we, acc_we;
        logic mem_re, mem_we, ld_flags, addr_sel, reg_or_mem, reg_sel, a_zero, b_zero;

        mc_cpu_controller_v2 #(
            .IR_W(8),
            .MEM_WAIT_EN((g == 0) ? 1 : 0),
            .WAIT_TIMEOUT((g == 0) ? 4 : 0)
        ) dut (
            .clk(clk),
            .rst(rst),
            .start(start),
            .mem_ready((g == 0) ? mem_ready : 1'b0),
            .ir(ir),
            .flags(flags),
            .done(done),
            .err(err),
            .pc_inc(pc_inc),
            .pc_load(pc_load),
            .ir_we(ir_we),
            .tr_we(tr_we),
            .a_we(a_we),
            .b_we(b_we),
            .alu_res_we(alu_res_we),
            .acc_we(acc_we),
            .mem_re(mem_re),
            .mem_we(mem_we),
            .ld_flags(ld_flags),
            .addr_sel(addr_sel),
            .reg_or_mem(reg_or_mem),
            .reg_sel(reg_sel),
            .a_zero(a_zero),
            .b_zero(b_zero),
            .alu_op(alu_op),
            .state(state)
        );

        assign obs[g] = {state, done, err, pc_inc, pc_load, ir_we, tr_we, a_we, b_we,
                         alu_res_we, acc_we, mem_re, mem_we, ld_flags, addr_sel,
                         reg_or_mem, reg_sel, a_zero, b_zero, alu_op};
    end

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] st(input int n);
        logic [23:0] v;
        v = '0;
        v[23:20] = 4'(n);
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic rst_v, input logic start_v, input logic rdy_v,
                                 input logic [7:0] ir_v, input logic [2:0] flags_v);
        @(posedge clk);
        #1;
        rst       = rst_v;
        start     = start_v;
        mem_ready = rdy_v;
        ir        = ir_v;
        flags     = flags_v;
    endtask

    // Queue the expected observation for the current cycle
    task automatic checkOutput(input int dut_id, input logic [23:0] exp, input string name);
        exp_t e;
        e.dut_id = dut_id;
        e.exp    = exp;
        e.name   = name;
        sb.push_back(e);
    endtask

    // Monitor: mid-cycle, compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [23:0] act;
            e   = sb.pop_front();
            act = obs[e.dut_id[0]];
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("[TB] FAIL %s (dut %0d): got %h expected %h", e.name, e.dut_id, act, e.exp);
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b1;
        ir        = IR_ADD;
        flags     = 3'b000;
        #2 rst = 1'b1;

        // Instance 0: ADD up to EXEC16, then reset in the middle of it
        applyStimulus(1, 0, 1, IR_ADD, 3'b000); checkOutput(0, st(0) | DONE, "reset_idle");
        applyStimulus(0, 1, 1, IR_ADD, 3'b000); checkOutput(0, st(0) | DONE, "idle_start_seen");
        applyStimulus(0, 0, 1, IR_ADD, 3'b000); checkOutput(0, st(1), "arm");
        applyStimulus(0, 0, 1, IR_ADD, 3'b000); checkOutput(0, st(2) | MEM_RE | IR_WE | PC_INC, "add_fetch");
        applyStimulus(0, 0, 1, IR_ADD, 3'b000); checkOutput(0, st(3), "add_decode");
        applyStimulus(0, 0, 1, IR_ADD, 3'b000); checkOutput(0, st(4) | MEM_RE | TR_WE | PC_INC, "add_fetch2");
        applyStimulus(0, 0, 1, IR_ADD, 3'b000);
        checkOutput(0, st(5) | A_WE | ADDR_SEL | MEM_RE | REG_OR_MEM | B_WE, "add_rdoper");
        applyStimulus(0, 0, 1, IR_ADD, 3'b000); checkOutput(0, st(6) | ALU_RES_WE | LD_FLAGS, "add_exec16");
        @(negedge clk);
        #1 rst = 1'b1;
        applyStimulus(1, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(0) | DONE, "reset_mid_exec16");
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(0) | DONE, "idle_after_reset");
        applyStimulus(0, 1, 1, IR_NOT, 3'b000); checkOutput(0, st(0) | DONE, "idle_start2");
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(1), "arm2");
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(2) | MEM_RE | IR_WE | PC_INC, "fetch_after_start");

        // NOT register op: LDREG, EXEC, WBREG
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(3), "not_decode");
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(8) | A_WE | B_WE | REG_SEL, "not_ldreg");
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(9) | ALU_RES_WE | LD_FLAGS | OP_NOT, "not_exec");
        applyStimulus(0, 0, 1, IR_NOT, 3'b000); checkOutput(0, st(10) | ACC_WE, "not_wbreg");

        // Jump on Z, taken then not taken
        applyStimulus(0, 0, 1, IR_JZ, 3'b010); checkOutput(0, st(2) | MEM_RE | IR_WE | PC_INC, "jz_fetch");
        applyStimulus(0, 0, 1, IR_JZ, 3'b010); checkOutput(0, st(3), "jz_decode");
        applyStimulus(0, 0, 1, IR_JZ, 3'b010); checkOutput(0, st(4) | MEM_RE | TR_WE | PC_INC, "jz_fetch2");
        applyStimulus(0, 0, 1, IR_JZ, 3'b010); checkOutput(0, st(11) | PC_LOAD, "jz_taken");
        applyStimulus(0, 0, 1, IR_JZ, 3'b000); checkOutput(0, st(2) | MEM_RE | IR_WE | PC_INC, "jz_fetch_b");
        applyStimulus(0, 0, 1, IR_JZ, 3'b000); checkOutput(0, st(3), "jz_decode_b");
        applyStimulus(0, 0, 1, IR_JZ, 3'b000); checkOutput(0, st(4) | MEM_RE | TR_WE | PC_INC, "jz_fetch2_b");
        applyStimulus(0, 0, 1, IR_JZ, 3'b000); checkOutput(0, st(11), "jz_not_taken");

        // STA: RDOPER ignores mem_ready, WB16 stalls three cycles
        applyStimulus(0, 0, 1, IR_STA, 3'b000); checkOutput(0, st(2) | MEM_RE | IR_WE | PC_INC, "sta_fetch");
        applyStimulus(0, 0, 1, IR_STA, 3'b000); checkOutput(0, st(3), "sta_decode");
        applyStimulus(0, 0, 1, IR_STA, 3'b000); checkOutput(0, st(4) | MEM_RE | TR_WE | PC_INC, "sta_fetch2");
        applyStimulus(0, 0, 0, IR_STA, 3'b000); checkOutput(0, st(5) | A_WE, "sta_rdoper_nostall");
        applyStimulus(0, 0, 0, IR_STA, 3'b000); checkOutput(0, st(6) | ALU_RES_WE | B_ZERO, "sta_exec16");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, IR_STA, 3'b000); checkOutput(0, st(7) | ADDR_SEL | MEM_WE, "sta_wb16_stall");
        end
        applyStimulus(0, 0, 1, IR_STA, 3'b000); checkOutput(0, st(7) | ADDR_SEL | MEM_WE, "sta_wb16_ready");

        // FETCH stuck: four stalled cycles then HALT with err
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, IR_STA, 3'b000); checkOutput(0, st(2) | MEM_RE, "fetch_stall");
        end
        applyStimulus(0, 0, 0, IR_STA, 3'b000); checkOutput(0, st(12) | DONE | ERR, "timeout_halt");
        applyStimulus(0, 1, 0, IR_STA, 3'b000); checkOutput(0, st(12) | DONE | ERR, "halt_err_sticky");
        applyStimulus(0, 0, 1, IR_HALT, 3'b000); checkOutput(0, st(1), "restart_clears_err");
        applyStimulus(0, 0, 1, IR_HALT, 3'b000); checkOutput(0, st(2) | MEM_RE | IR_WE | PC_INC, "halt_fetch");
        applyStimulus(0, 0, 1, IR_HALT, 3'b000); checkOutput(0, st(3), "halt_decode");
        applyStimulus(0, 0, 1, IR_HALT, 3'b000); checkOutput(0, st(12) | DONE, "halt_instr");

        // Instance 1 (mem_ready ignored, tied low): ADD takes six cycles
        applyStimulus(1, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(0) | DONE, "nw_reset");
        applyStimulus(0, 1, 0, IR_ADD, 3'b000); checkOutput(1, st(0) | DONE, "nw_idle");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(1), "nw_arm");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(2) | MEM_RE | IR_WE | PC_INC, "nw_fetch");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(3), "nw_decode");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(4) | MEM_RE | TR_WE | PC_INC, "nw_fetch2");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000);
        checkOutput(1, st(5) | A_WE | ADDR_SEL | MEM_RE | REG_OR_MEM | B_WE, "nw_rdoper");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(6) | ALU_RES_WE | LD_FLAGS, "nw_exec16");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(7) | ACC_WE, "nw_wb16");
        applyStimulus(0, 0, 0, IR_ADD, 3'b000); checkOutput(1, st(2) | MEM_RE | IR_WE | PC_INC, "nw_next_fetch");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
